uart_rx_core: RTL and testbench

//  Serial receive front-end feeding the IO datapath's UART register window (0x0040_01xx).

---
 rtl/uart_rx_core.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receive front-end: rx synchroniser, mid-bit sampling FSM and a holding
// register with ready/overrun/frame-error status for the IO datapath.
module uart_rx_core #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  input  logic                 rd_ack,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_ferr;
  logic                   r_ovr;

  logic                   w_rxs;
  logic                   w_fall;
  logic                   w_expire;
  logic [DIV_WIDTH-1:0]   w_n;
  logic                   w_load;
  logic                   w_ferr_set;
  logic                   w_ovr_set;

  assign w_rxs    = r_sync[SYNC_STAGES-1];
  assign w_fall   = r_rxs_prev & ~w_rxs;
  assign w_expire = (r_cnt <= DIV_WIDTH'(1));
  assign w_n      = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;

  // rx synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rxs_prev <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; the counter expires on its last clock of the bit (value 1)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_expire ? r_cnt : r_cnt - DIV_WIDTH'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr_set  = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_fall) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = w_n >> 1;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = w_n;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        S_DATA: begin
          if (w_expire) begin
            w_shift_nxt[r_idx] = w_rxs;
            w_cnt_nxt          = w_n;
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              w_state_nxt = S_STOP;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        S_STOP: begin
          if (w_expire) begin
            w_load      = w_rxs;
            w_ferr_set  = ~w_rxs;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_ovr_set = w_load & r_ready & ~rd_ack;

  // Holding register and sticky status; set events beat err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_data  <= w_shift_nxt;
        r_ready <= 1'b1;
      end else if (rd_ack) begin
        r_ready <= 1'b0;
      end
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (err_clr) begin
        r_ferr <= 1'b0;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (err_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_ready  = r_ready;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing, exact latency, overrun, frame error,
// glitch rejection, enable abort, async reset and the minimum divider clamp.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] baud_div;
  logic        rx;
  logic        rd_ack;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  uart_rx_core #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .DIV_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .baud_div (baud_div),
    .rx       (rx),
    .rd_ack   (rd_ack),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start + data bits; returns just after the edge where the stop level is driven
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int n);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (n) @(posedge clk);
      #1 rx = d[i];
    end
    repeat (n) @(posedge clk);
    #1 rx = stop;
  endtask

  task automatic finish_frame(input int n);
    repeat (n) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd_ack();
    @(posedge clk); #1 rd_ack = 1'b1;
    @(posedge clk); #1 rd_ack = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; baud_div = 16'd95; rx = 1'b1; rd_ack = 1'b0; err_clr = 1'b0;
    #12;
    check("rst_data",  32'(rx_data),   32'h00);
    check("rst_ready", 32'(rx_ready),  32'h0);
    check("rst_busy",  32'(rx_busy),   32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovr",   32'(overrun),   32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(5);

    // 0xA5 at N=95: load edge is 2+47+855+1 = 905 clocks after rx falls
    drive_frame(8'hA5, 1'b1, 95);
    check("t2_busy", 32'(rx_busy), 32'h1);
    repeat (49) @(posedge clk);
    #1;
    check("t2_ready_early", 32'(rx_ready), 32'h0);
    @(posedge clk); #1;
    check("t2_ready_on_time", 32'(rx_ready),  32'h1);
    check("t2_data",          32'(rx_data),   32'hA5);
    check("t2_ferr",          32'(frame_err), 32'h0);
    repeat (45) @(posedge clk);
    idle(5);
    check("t2_busy_done", 32'(rx_busy), 32'h0);
    pulse_rd_ack();
    check("t2_ready_ack", 32'(rx_ready), 32'h0);
    check("t2_data_kept", 32'(rx_data),  32'hA5);

    // Back-to-back 0x12, 0x34 without rd_ack
    drive_frame(8'h12, 1'b1, 95);
    finish_frame(95);
    drive_frame(8'h34, 1'b1, 95);
    finish_frame(95);
    idle(5);
    check("t3_data",  32'(rx_data),  32'h34);
    check("t3_ready", 32'(rx_ready), 32'h1);
    check("t3_ovr",   32'(overrun),  32'h1);
    check("t3_ferr",  32'(frame_err), 32'h0);
    pulse_err_clr();
    check("t3_ovr_clr",   32'(overrun),  32'h0);
    check("t3_ready_kep", 32'(rx_ready), 32'h1);

    // 0x55 with a low stop bit
    drive_frame(8'h55, 1'b0, 95);
    finish_frame(95);
    idle(5);
    check("t4_ferr",  32'(frame_err), 32'h1);
    check("t4_data",  32'(rx_data),   32'h34);
    check("t4_ready", 32'(rx_ready),  32'h1);
    check("t4_ovr",   32'(overrun),   32'h0);
    pulse_err_clr();
    check("t4_ferr_clr", 32'(frame_err), 32'h0);
    pulse_rd_ack();
    check("t4_ready_ack", 32'(rx_ready), 32'h0);

    // 20-clock low glitch
    @(posedge clk); #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_busy_start", 32'(rx_busy), 32'h1);
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    idle(60);
    check("t5_busy",  32'(rx_busy),   32'h0);
    check("t5_ready", 32'(rx_ready),  32'h0);
    check("t5_ferr",  32'(frame_err), 32'h0);
    check("t5_ovr",   32'(overrun),   32'h0);

    // rd_ack coincident with the second load
    drive_frame(8'h9C, 1'b1, 95);
    finish_frame(95);
    idle(5);
    check("t6_data1",  32'(rx_data),  32'h9C);
    check("t6_ready1", 32'(rx_ready), 32'h1);
    drive_frame(8'h3E, 1'b1, 95);
    repeat (49) @(posedge clk);
    #1 rd_ack = 1'b1;
    @(posedge clk); #1 rd_ack = 1'b0;
    check("t6_ready2", 32'(rx_ready), 32'h1);
    check("t6_data2",  32'(rx_data),  32'h3E);
    check("t6_ovr",    32'(overrun),  32'h0);
    repeat (45) @(posedge clk);
    idle(5);

    // en dropped mid-frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("t6_busy_mid", 32'(rx_busy), 32'h1);
    en = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_abort", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    idle(20);
    rx = 1'b0;
    idle(20);
    check("t6_busy_disabled", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    idle(20);
    en = 1'b1;
    idle(20);
    check("t6_busy_reen", 32'(rx_busy),   32'h0);
    check("t6_ready_kep", 32'(rx_ready),  32'h1);
    check("t6_data_kep",  32'(rx_data),   32'h3E);
    check("t6_ferr",      32'(frame_err), 32'h0);
    check("t6_ovr2",      32'(overrun),   32'h0);

    // Async reset during DATA
    @(posedge clk); #1 rx = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("t1_busy_mid", 32'(rx_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_data",  32'(rx_data),   32'h00);
    check("t1_ready", 32'(rx_ready),  32'h0);
    check("t1_busy",  32'(rx_busy),   32'h0);
    check("t1_ferr",  32'(frame_err), 32'h0);
    check("t1_ovr",   32'(overrun),   32'h0);
    rx = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(5);
    check("t1_busy_after", 32'(rx_busy), 32'h0);

    // baud_div=0 clamps to N=2
    baud_div = 16'd0;
    drive_frame(8'hC3, 1'b1, 2);
    finish_frame(2);
    idle(5);
    check("div0_data",  32'(rx_data),   32'hC3);
    check("div0_ready", 32'(rx_ready),  32'h1);
    check("div0_ferr",  32'(frame_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
